// File: rtl/sample_ram_controller_pkg.sv
// Shared definitions for the sample RAM controller: default RAM depth and
// the encoding of the read-out state machine.
package sample_ram_controller_pkg;

    // Default log2 of the sample RAM depth.
    localparam int DEFAULT_RAM_ADDR_WIDTH = 8;

    // Every byte on the Tx interface is this wide.
    localparam int TX_DATA_WIDTH = 8;

    // Read-out sequence: fetch a word, latch it onto tx_data, then wait in SEND
    // until the Tx protocol acknowledges it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample memory: one write port and one registered read
// port with one cycle of latency. The contents are never cleared, so
// synthesis can map it onto block RAM.
module sample_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_wrEn,
    input  logic [ADDR_WIDTH-1:0] i_wrAddr,
    input  logic [DATA_WIDTH-1:0] i_wrData,
    input  logic                  i_rdEn,
    input  logic [ADDR_WIDTH-1:0] i_rdAddr,
    output logic [DATA_WIDTH-1:0] o_rdData
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    // Write port: store one sample per enabled cycle.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Registered read port. It has no reset, so it can be absorbed into the RAM primitive.
    always_ff @(posedge clk) begin
        if (i_rdEn) begin
            o_rdData <= r_mem[i_rdAddr];
        end
    end

endmodule

// File: rtl/sample_ram_controller.sv
// Sample RAM controller: records ADC samples into a circular RAM while the
// trigger block holds we high. On a host request, it streams the most recent
// num_samples samples, oldest first, over a rdy/ack/eof handshake.
module sample_ram_controller
    import sample_ram_controller_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = DEFAULT_RAM_ADDR_WIDTH,
    parameter int BITS_ADC       = 8,
    parameter int REG_DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [BITS_ADC-1:0]       adc_data,
    input  logic                      adc_rdy,
    input  logic [REG_DATA_WIDTH-1:0] num_samples,
    input  logic                      rqst_data,
    output logic [TX_DATA_WIDTH-1:0]  tx_data,
    output logic                      tx_rdy,
    output logic                      tx_eof,
    input  logic                      tx_ack,
    output logic                      busy
);

    localparam int DEPTH     = 2 ** RAM_ADDR_WIDTH;
    localparam int LEN_WIDTH = REG_DATA_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] DEPTH_LEN = LEN_WIDTH'(DEPTH);

    state_t                      r_state;
    state_t                      w_nextState;
    logic [RAM_ADDR_WIDTH-1:0]   r_wrPtr;
    logic [RAM_ADDR_WIDTH-1:0]   r_rdPtr;
    logic [LEN_WIDTH-1:0]        r_remaining;
    logic [TX_DATA_WIDTH-1:0]    r_txData;
    logic                        r_txRdy;
    logic                        r_txEof;

    logic [LEN_WIDTH-1:0]        w_numExt;
    logic [LEN_WIDTH-1:0]        w_len;
    logic                        w_write;
    logic                        w_startReq;
    logic                        w_ackSend;
    logic                        w_lastByte;
    logic [BITS_ADC-1:0]         w_ramQ;
    logic [TX_DATA_WIDTH-1:0]    w_txByte;

    // Clamp the requested length to the RAM depth. The extra bit keeps a full-depth request distinct from zero.
    assign w_numExt   = {1'b0, num_samples};
    assign w_len      = (w_numExt > DEPTH_LEN) ? DEPTH_LEN : w_numExt;

    // Samples are recorded only in IDLE. A request and a write in the same cycle both take effect.
    assign w_write    = we && adc_rdy && (r_state == ST_IDLE);
    assign w_startReq = rqst_data && (r_state == ST_IDLE) && (w_len != '0);
    assign w_ackSend  = tx_ack && (r_state == ST_SEND);
    assign w_lastByte = (r_remaining == LEN_WIDTH'(1));

    // BITS_ADC is at most 8, so the cast zero-extends the sample onto the byte lane.
    assign w_txByte   = TX_DATA_WIDTH'(w_ramQ);

    sample_ram #(
        .ADDR_WIDTH (RAM_ADDR_WIDTH),
        .DATA_WIDTH (BITS_ADC)
    ) u_sampleRam (
        .clk      (clk),
        .i_wrEn   (w_write),
        .i_wrAddr (r_wrPtr),
        .i_wrData (adc_data),
        .i_rdEn   (r_state == ST_FETCH),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_ramQ)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: request -> fetch -> latch -> send, then loop until the last byte is acknowledged.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_startReq) begin
                    w_nextState = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_nextState = ST_LATCH;
            end
            ST_LATCH: begin
                w_nextState = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ack) begin
                    w_nextState = w_lastByte ? ST_IDLE : ST_FETCH;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Pointers and the byte counter. The read start uses wr_ptr as it was before any write in this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_remaining <= '0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + RAM_ADDR_WIDTH'(1);
            end
            if (w_startReq) begin
                r_rdPtr     <= r_wrPtr - w_len[RAM_ADDR_WIDTH-1:0];
                r_remaining <= w_len;
            end else if (w_ackSend) begin
                r_rdPtr     <= r_rdPtr + RAM_ADDR_WIDTH'(1);
                r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
        end
    end

    // Tx byte lane: load in LATCH, hold through SEND, and drop rdy/eof after the acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txData <= '0;
            r_txRdy  <= 1'b0;
            r_txEof  <= 1'b0;
        end else if (r_state == ST_LATCH) begin
            r_txData <= w_txByte;
            r_txRdy  <= 1'b1;
            r_txEof  <= w_lastByte;
        end else if (w_ackSend) begin
            r_txRdy  <= 1'b0;
            r_txEof  <= 1'b0;
        end
    end

    assign tx_data = r_txData;
    assign tx_rdy  = r_txRdy;
    assign tx_eof  = r_txEof;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sample_ram_controller.sv
// Bench for the sample RAM controller. It uses a 16-word RAM so that wrap-around
// and clamping to full depth stay short. The checks cover table-driven frames and
// hand-built sequences for stalls, ignored inputs, zero length and reset mid-frame.
module tb_sample_ram_controller;

    localparam int AW = 4;

    logic        clk;
    logic        rst;
    logic        we;
    logic [7:0]  adc_data;
    logic        adc_rdy;
    logic [15:0] num_samples;
    logic        rqst_data;
    logic [7:0]  tx_data;
    logic        tx_rdy;
    logic        tx_eof;
    logic        tx_ack;
    logic        busy;

    int testsRun;
    int testsFailed;
    logic [7:0] expBytes [0:31];

    typedef struct {
        int startVal;
        int writeCount;
        int numSamples;
        int expFirst;
        int expCount;
    } vec_t;

    vec_t vectors [0:5];

    sample_ram_controller #(
        .RAM_ADDR_WIDTH (AW),
        .BITS_ADC       (8),
        .REG_DATA_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .adc_data    (adc_data),
        .adc_rdy     (adc_rdy),
        .num_samples (num_samples),
        .rqst_data   (rqst_data),
        .tx_data     (tx_data),
        .tx_rdy      (tx_rdy),
        .tx_eof      (tx_eof),
        .tx_ack      (tx_ack),
        .busy        (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so that a hung handshake cannot stall the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int startVal, input int count);
        for (int i = 0; i < count; i++) begin
            we       = 1'b1;
            adc_rdy  = 1'b1;
            adc_data = 8'(startVal + i);
            tick();
        end
        we      = 1'b0;
        adc_rdy = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Wait for tx_rdy. The count is the number of clock edges since the event
    // that should lead to it, starting from the edge that was already taken.
    task automatic waitRdy(inout int cycles);
        while (!tx_rdy && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    // Request a frame and consume it. The expected bytes come from expBytes[0..len-1].
    task automatic readFrame(input int len, input int stall, input bit ackFetch,
                             input int lateNum, input string name);
        int cycles;
        rqst_data = 1'b1;
        tick();
        rqst_data = 1'b0;
        cycles = 1;
        if (lateNum >= 0) num_samples = 16'(lateNum);
        if (ackFetch) begin
            tx_ack = 1'b1;
            tick();
            tx_ack = 1'b0;
            cycles = 2;
        end
        for (int b = 0; b < len; b++) begin
            waitRdy(cycles);
            checkOutput($sformatf("%s latency b%0d", name, b), cycles, 3);
            checkOutput($sformatf("%s data b%0d", name, b), int'(tx_data), int'(expBytes[b]));
            checkOutput($sformatf("%s eof b%0d", name, b), int'(tx_eof), (b == len - 1) ? 1 : 0);
            checkOutput($sformatf("%s busy b%0d", name, b), int'(busy), 1);
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    rqst_data = 1'b1;
                    tick();
                    checkOutput($sformatf("%s stall rdy s%0d", name, s), int'(tx_rdy), 1);
                    checkOutput($sformatf("%s stall data s%0d", name, s), int'(tx_data), int'(expBytes[0]));
                    checkOutput($sformatf("%s stall eof s%0d", name, s), int'(tx_eof), (len == 1) ? 1 : 0);
                end
                rqst_data = 1'b0;
            end
            tx_ack = 1'b1;
            tick();
            tx_ack = 1'b0;
            cycles = 1;
            checkOutput($sformatf("%s rdy drop b%0d", name, b), int'(tx_rdy), 0);
            checkOutput($sformatf("%s eof drop b%0d", name, b), int'(tx_eof), 0);
        end
        checkOutput($sformatf("%s idle after", name), int'(busy), 0);
    endtask

    initial begin
        int  cycles;
        bit  sawRdy;
        bit  sawBusy;

        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        we          = 1'b0;
        adc_data    = '0;
        adc_rdy     = 1'b0;
        num_samples = '0;
        rqst_data   = 1'b0;
        tx_ack      = 1'b0;

        // Each frame is taken after a fresh reset: {first value written, write count,
        // num_samples, first expected byte, expected byte count}.
        vectors[0] = '{0,   10, 4,     6,   4};
        vectors[1] = '{0,   20, 6,     14,  6};
        vectors[2] = '{0,   20, 40,    4,   16};
        vectors[3] = '{100, 31, 16,    115, 16};
        vectors[4] = '{200, 5,  1,     204, 1};
        vectors[5] = '{50,  16, 65535, 50,  16};

        tick();
        tick();
        checkOutput("reset tx_rdy", int'(tx_rdy), 0);
        checkOutput("reset tx_eof", int'(tx_eof), 0);
        checkOutput("reset tx_data", int'(tx_data), 0);
        checkOutput("reset busy", int'(busy), 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            doReset();
            applyStimulus(vectors[v].startVal, vectors[v].writeCount);
            num_samples = 16'(vectors[v].numSamples);
            for (int i = 0; i < vectors[v].expCount; i++) begin
                expBytes[i] = 8'(vectors[v].expFirst + i);
            end
            readFrame(vectors[v].expCount, 0, 1'b0, -1, $sformatf("vec%0d", v));
        end

        // A stalled first byte, writes held during the frame, and a request
        // repeated while in SEND. The write in the request cycle lands at
        // address 10 and is not part of this frame.
        doReset();
        applyStimulus(0, 10);
        we       = 1'b1;
        adc_rdy  = 1'b1;
        adc_data = 8'hEE;
        num_samples = 16'd3;
        expBytes[0] = 8'd7;
        expBytes[1] = 8'd8;
        expBytes[2] = 8'd9;
        readFrame(3, 5, 1'b0, -1, "stall");
        we      = 1'b0;
        adc_rdy = 1'b0;

        // An ack in IDLE and an ack in FETCH must not move the pointers. A change to
        // num_samples after the request must not shorten the frame.
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        num_samples = 16'd4;
        expBytes[0] = 8'd7;
        expBytes[1] = 8'd8;
        expBytes[2] = 8'd9;
        expBytes[3] = 8'hEE;
        readFrame(4, 0, 1'b1, 1, "ackIgnore");

        // we without adc_rdy, and adc_rdy without we, must not write anything.
        we       = 1'b1;
        adc_rdy  = 1'b0;
        adc_data = 8'h55;
        tick();
        tick();
        tick();
        we      = 1'b0;
        adc_rdy = 1'b1;
        adc_data = 8'h66;
        tick();
        tick();
        adc_rdy = 1'b0;

        // A zero-length request is ignored.
        num_samples = 16'd0;
        rqst_data = 1'b1;
        tick();
        rqst_data = 1'b0;
        sawRdy  = 1'b0;
        sawBusy = 1'b0;
        if (busy) sawBusy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_rdy) sawRdy = 1'b1;
            if (busy) sawBusy = 1'b1;
        end
        checkOutput("zeroLen rdy", int'(sawRdy), 0);
        checkOutput("zeroLen busy", int'(sawBusy), 0);
        num_samples = 16'd2;
        expBytes[0] = 8'd9;
        expBytes[1] = 8'hEE;
        readFrame(2, 0, 1'b0, -1, "afterZero");

        // Reset while the third byte of an 8-byte frame is presented.
        // Before the reset, address i holds i, except that addresses 0..4 hold 16..20.
        doReset();
        applyStimulus(0, 16);
        applyStimulus(16, 5);
        num_samples = 16'd8;
        rqst_data = 1'b1;
        tick();
        rqst_data = 1'b0;
        cycles = 1;
        for (int b = 0; b < 2; b++) begin
            waitRdy(cycles);
            checkOutput($sformatf("abort data b%0d", b), int'(tx_data), 13 + b);
            tx_ack = 1'b1;
            tick();
            tx_ack = 1'b0;
            cycles = 1;
        end
        waitRdy(cycles);
        checkOutput("abort third rdy", int'(tx_rdy), 1);
        checkOutput("abort third data", int'(tx_data), 15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort tx_rdy", int'(tx_rdy), 0);
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort tx_eof", int'(tx_eof), 0);
        checkOutput("abort tx_data", int'(tx_data), 0);
        // wr_ptr restarts at 0: 40 and 41 land at addresses 0 and 1, so four samples start at address 14.
        applyStimulus(40, 2);
        num_samples = 16'd4;
        expBytes[0] = 8'd14;
        expBytes[1] = 8'd15;
        expBytes[2] = 8'd40;
        expBytes[3] = 8'd41;
        readFrame(4, 0, 1'b0, -1, "postAbort");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
